// File: rtl/jinverter_bist_ctrl.sv
// BIST sequencer for a bank of inverter cells: drives four patterns, waits a
// settle time, checks resp == ~stim and counts the patterns that mismatch.
module jinverter_bist_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       fail_cnt,
    output logic [1:0]       first_fail
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic [1:0]     p;
    logic           aborting;

    // Pattern 2 is ...1010 (bit 0 clear); pattern 3 is its complement.
    function automatic logic [WIDTH-1:0] pattern(input logic [1:0] idx);
        logic [WIDTH-1:0] alt;
        alt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            alt[i] = (i % 2 == 1);
        end
        case (idx)
            2'd0:    pattern = '1;
            2'd1:    pattern = '0;
            2'd2:    pattern = alt;
            default: pattern = ~alt;
        endcase
    endfunction

    assign aborting = abort && (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_DRIVE;
            end
            S_DRIVE: begin
                busy    = 1'b1;
                state_n = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == '0) state_n = S_CHECK;
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_n = (p == 2'd3) ? S_FINISH : S_DRIVE;
            end
            S_FINISH: begin
                done    = !abort;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (aborting) begin
            state_n = S_IDLE;
            busy    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim       <= '0;
            pass       <= 1'b0;
            fail_cnt   <= 3'd0;
            first_fail <= 2'd0;
            cnt        <= '0;
            p          <= 2'd0;
        end else if (aborting) begin
            // Partial fail_cnt/first_fail stay visible after an abort.
            stim <= '0;
            pass <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p          <= 2'd0;
                        fail_cnt   <= 3'd0;
                        first_fail <= 2'd0;
                    end
                end
                S_DRIVE: begin
                    stim <= pattern(p);
                    cnt  <= CW'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_CHECK: begin
                    // Four-state compare so X/Z on the bank output is a failure.
                    if (resp !== ~stim) begin
                        if (fail_cnt == 3'd0) first_fail <= p;
                        fail_cnt <= fail_cnt + 3'd1;
                    end
                    if (p != 2'd3) p <= p + 2'd1;
                end
                S_FINISH: begin
                    pass <= (fail_cnt == 3'd0);
                    stim <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jinverter_bist_ctrl.sv
// Scoreboard bench for jinverter_bist_ctrl: a behavioural inverter bank with
// configurable delay and a stuck bit; run results are checked at each done pulse.
module tb_jinverter_bist_ctrl;

    localparam int WIDTH  = 8;
    localparam int SETTLE = 4;

    typedef struct {
        int         done_cyc;
        logic       pass;
        logic [2:0] fc;
        logic [1:0] ff;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] resp;
    logic [WIDTH-1:0] stim;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2:0]       fail_cnt;
    logic [1:0]       first_fail;

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   bank_delay = 1;
    logic stuck3     = 1'b0;

    logic [WIDTH-1:0] hist [8] = '{default: '0};
    logic [WIDTH-1:0] pats [4] = '{8'hFF, 8'h00, 8'hAA, 8'h55};

    exp_t sb_q[$];
    logic pass_pending = 1'b0;
    logic pass_exp     = 1'b0;

    jinverter_bist_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .resp       (resp),
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_cnt   (fail_cnt),
        .first_fail (first_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: resp in cycle t is ~stim from cycle t-bank_delay.
    always @(posedge clk) begin
        hist[0] <= stim;
        for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
    end

    always_comb begin
        resp = ~hist[bank_delay-1];
        if (stuck3) resp[3] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per done pulse; pass is checked a
    // cycle later, once the FINISH edge has updated it.
    always @(negedge clk) begin
        if (pass_pending) begin
            check("pass_after_done", 32'(pass), 32'(pass_exp));
        end
        pass_pending <= 1'b0;
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(sb_q.size()), 32'd1);
            end else begin
                check("done_cycle", 32'(cyc), 32'(sb_q[0].done_cyc));
                check("fail_cnt", 32'(fail_cnt), 32'(sb_q[0].fc));
                check("first_fail", 32'(first_fail), 32'(sb_q[0].ff));
                pass_exp     <= sb_q[0].pass;
                pass_pending <= 1'b1;
                sb_q.delete(0);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // One run; n counts cycles after the edge that sampled start (n=1 is DRIVE).
    task automatic run(input int dly, input logic stk, input logic [2:0] fc,
                       input logic [1:0] ff, input logic ps, input int abort_at,
                       input bit spam);
        exp_t e;
        bank_delay = dly;
        stuck3     = stk;
        repeat (8) @(posedge clk);
        #1;
        pulse_start();
        if (abort_at == 0) begin
            e.done_cyc = cyc + 24;
            e.pass     = ps;
            e.fc       = fc;
            e.ff       = ff;
            sb_q.push_back(e);
        end
        for (int n = 1; n <= 26; n++) begin
            if (abort_at == 0) begin
                if (n == 1) check("busy_in_drive", 32'(busy), 32'd1);
                if (n % 6 == 0 && n <= 24) check("stim_in_check", 32'(stim), 32'(pats[n/6-1]));
                if (n == 25) check("busy_in_finish", 32'(busy), 32'd0);
                if (n == 26) begin
                    check("stim_idle", 32'(stim), 32'd0);
                    check("done_seen", 32'(sb_q.size()), 32'd0);
                end
            end else begin
                abort = (n == abort_at);
                if (n == abort_at + 1) begin
                    check("abort_stim", 32'(stim), 32'd0);
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_pass", 32'(pass), 32'd0);
                    check("abort_fail_cnt", 32'(fail_cnt), 32'(fc));
                    check("abort_first_fail", 32'(first_fail), 32'(ff));
                end
            end
            start = spam && (n == 3 || n == 11 || n == 24);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stim", 32'(stim), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        check("rst_first_fail", 32'(first_fail), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(1, 1'b0, 3'd0, 2'd0, 1'b1, 0, 1'b0);   // good bank
        run(1, 1'b1, 3'd2, 2'd1, 1'b0, 0, 1'b0);   // bit 3 stuck low
        run(5, 1'b0, 3'd4, 2'd0, 1'b0, 0, 1'b0);   // bank too slow: all stale
        run(1, 1'b0, 3'd0, 2'd0, 1'b1, 0, 1'b0);   // clean run restores pass
        run(1, 1'b1, 3'd1, 2'd1, 1'b0, 15, 1'b0);  // abort in SETTLE of pattern 2
        run(1, 1'b0, 3'd0, 2'd0, 1'b1, 0, 1'b0);   // clean run after abort
        run(1, 1'b0, 3'd0, 2'd0, 1'b1, 0, 1'b1);   // start spam ignored

        // Async reset in CHECK of pattern 0, between clock edges.
        bank_delay = 1;
        stuck3     = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pulse_start();
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_stim", 32'(stim), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_pass", 32'(pass), 32'd0);
        check("async_rst_fail_cnt", 32'(fail_cnt), 32'd0);
        check("async_rst_first_fail", 32'(first_fail), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(1, 1'b0, 3'd0, 2'd0, 1'b1, 0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
